// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo - oversampled UART receiver with runtime frame format, per-entry
// error tags, show-ahead RX FIFO and RTS flow control.
//
// Optional feature macro: UART_RX_BREAK_DET_EN
//   defined   : break frames push 0x00 tagged {break,frame}; the receiver then
//               waits for one full bit time of idle-high before re-arming.
//   undefined : no break detection; rd_err[2] is always 0.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rx                  asynchronous serial input (idle high)
//   baud_div            oversample tick every baud_div+1 clocks
//   cfg_data_bits       0..3 selects 5..8 data bits
//   cfg_stop_bits       0 = one stop bit, 1 = two stop bits
//   cfg_parity_en       parity bit present
//   cfg_parity_even     1 = even parity, 0 = odd parity
//   rd_en               pop head entry (ignored when empty)
//   rd_data, rd_err     head entry data (LSB aligned) and {break, frame, parity} tags
//   empty, full, level  FIFO status
//   overrun, ovr_clr    sticky frame-dropped flag and its clear
//   rts_n               0 = ready to receive
module uart_rx_fifo #(
  parameter int FIFO_DEPTH  = 16,
  parameter int OVS         = 16,
  parameter int DIV_W       = 16,
  parameter int RTS_THRESH  = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx,
  input  logic [DIV_W-1:0]                baud_div,
  input  logic [1:0]                      cfg_data_bits,
  input  logic                            cfg_stop_bits,
  input  logic                            cfg_parity_en,
  input  logic                            cfg_parity_even,
  input  logic                            rd_en,
  output logic [7:0]                      rd_data,
  output logic [2:0]                      rd_err,
  output logic                            empty,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
  output logic                            overrun,
  input  logic                            ovr_clr,
  output logic                            rts_n
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(FIFO_DEPTH+1);
  localparam int OW  = $clog2(OVS);
  localparam int MID = OVS / 2;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
`ifdef UART_RX_BREAK_DET_EN
    , BRK_WAIT
`endif
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s, rx_d, fall;
  logic [DIV_W-1:0]       div_cnt;
  logic                   tick;
  logic [OW-1:0]          os_cnt;
  logic [1:0]             smp;
  logic                   maj, at_mid, at_end, at_smp;
  logic [2:0]             bit_cnt;
  logic [1:0]             dbits_l;
  logic                   stop2_l, par_en_l, par_even_l;
  logic [7:0]             data;
  logic                   pbit, perr, ferr, brk;
  logic                   push;
  logic [7:0]             push_data;
  logic [2:0]             push_err;

  // Input synchroniser and falling-edge detect on the synchronised value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
      rx_d <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      rx_d <= rx_s;
    end
  end

  assign rx_s = sync[SYNC_STAGES-1];
  assign fall = rx_d & ~rx_s;

  // Oversample tick generator; realigned to the start edge so bit phase is exact
  assign tick = (div_cnt >= baud_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             div_cnt <= '0;
    else if (tick || (state == IDLE && fall)) div_cnt <= '0;
    else                                    div_cnt <= div_cnt + 1'b1;
  end

  // Three samples around mid-bit; the decision is taken on the last of them
  assign at_smp = (os_cnt == OW'(MID-2)) || (os_cnt == OW'(MID-1));
  assign at_mid = (os_cnt == OW'(MID));
  assign at_end = (os_cnt == OW'(OVS-1));
  assign maj    = (smp[1] & smp[0]) | (smp[1] & rx_s) | (smp[0] & rx_s);
  assign brk    = (data == 8'h00) && !maj && (!par_en_l || !pbit);

  // Receive FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      os_cnt     <= '0;
      smp        <= '0;
      bit_cnt    <= '0;
      dbits_l    <= '0;
      stop2_l    <= 1'b0;
      par_en_l   <= 1'b0;
      par_even_l <= 1'b0;
      data       <= '0;
      pbit       <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      push       <= 1'b0;
      push_data  <= '0;
      push_err   <= '0;
    end else begin
      push <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state  <= START;
            os_cnt <= '0;
            smp    <= '0;
          end
        end
`ifdef UART_RX_BREAK_DET_EN
        BRK_WAIT: begin
          // Re-arm only after rx has stayed high for one whole bit time
          if (tick) begin
            if (!rx_s)       os_cnt <= '0;
            else if (at_end) state  <= IDLE;
            else             os_cnt <= os_cnt + 1'b1;
          end
        end
`endif
        default: begin
          if (tick) begin
            os_cnt <= at_end ? '0 : os_cnt + 1'b1;
            if (at_smp) smp <= {smp[0], rx_s};
            case (state)
              START: begin
                if (at_mid) begin
                  if (maj) begin
                    state <= IDLE;
                  end else begin
                    dbits_l    <= cfg_data_bits;
                    stop2_l    <= cfg_stop_bits;
                    par_en_l   <= cfg_parity_en;
                    par_even_l <= cfg_parity_even;
                    data       <= '0;
                    bit_cnt    <= '0;
                    perr       <= 1'b0;
                    ferr       <= 1'b0;
                  end
                end else if (at_end) begin
                  state <= DATA;
                end
              end
              DATA: begin
                if (at_mid) data[bit_cnt] <= maj;
                if (at_end) begin
                  if (bit_cnt == 3'(dbits_l) + 3'd4) state <= par_en_l ? PARITY : STOP1;
                  else                               bit_cnt <= bit_cnt + 1'b1;
                end
              end
              PARITY: begin
                if (at_mid) begin
                  pbit <= maj;
                  perr <= (^data) ^ maj ^ ~par_even_l;
                end
                if (at_end) state <= STOP1;
              end
              STOP1: begin
                if (at_mid) begin
`ifdef UART_RX_BREAK_DET_EN
                  if (brk) begin
                    push      <= 1'b1;
                    push_data <= 8'h00;
                    push_err  <= 3'b110;
                    state     <= BRK_WAIT;
                    os_cnt    <= '0;
                  end else
`endif
                  if (stop2_l) begin
                    ferr <= !maj;
                  end else begin
                    push      <= 1'b1;
                    push_data <= data;
                    push_err  <= {1'b0, !maj, perr};
                    state     <= IDLE;
                  end
                end else if (at_end) begin
                  state <= STOP2;
                end
              end
              STOP2: begin
                if (at_mid) begin
                  push      <= 1'b1;
                  push_data <= data;
                  push_err  <= {1'b0, ferr | !maj, perr};
                  state     <= IDLE;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // Show-ahead FIFO
  logic [10:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          pop, do_push;

  assign empty   = (level == '0);
  assign full    = (level == LW'(FIFO_DEPTH));
  assign pop     = rd_en & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push
  assign do_push = push & (~full | pop);
  assign rd_data = empty ? 8'h00 : mem[rptr][7:0];
  assign rd_err  = empty ? 3'b000 : mem[rptr][10:8];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= {push_err, push_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      overrun <= 1'b0;
      rts_n   <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({do_push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && full && !pop) overrun <= 1'b1;
      else if (ovr_clr)         overrun <= 1'b0;
      rts_n <= (level >= LW'(RTS_THRESH));
    end
  end

  // brk only feeds the optional break path
  logic unused_ok;
  assign unused_ok = brk;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are driven bit by bit at
// 64 clocks per bit (baud_div=3, OVS=16); the expected FIFO entry is queued
// when a frame is sent and a forked monitor pops and compares entries.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic [1:0]  cfg_data_bits = 2'd3;
  logic        cfg_stop_bits = 1'b0;
  logic        cfg_parity_en = 1'b0;
  logic        cfg_parity_even = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_data;
  logic [2:0]  rd_err;
  logic        empty, full;
  logic [4:0]  level;
  logic        overrun;
  logic        ovr_clr = 1'b0;
  logic        rts_n;

  uart_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .baud_div(baud_div),
    .cfg_data_bits(cfg_data_bits), .cfg_stop_bits(cfg_stop_bits),
    .cfg_parity_en(cfg_parity_en), .cfg_parity_even(cfg_parity_even),
    .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err), .empty(empty),
    .full(full), .level(level), .overrun(overrun), .ovr_clr(ovr_clr),
    .rts_n(rts_n)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          pops_done = 0;
  int          pop_limit = 1000000;
  logic [10:0] exp_q[$];

  localparam int BIT_CLKS = 64;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && !empty && pops_done < pop_limit) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_entry: got err=%b data=%h expected none", rd_err, rd_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_entry{err,data}", 32'({rd_err, rd_data}), 32'(e));
        end
        rd_en = 1'b1;
        pops_done++;
      end else begin
        rd_en = 1'b0;
      end
    end
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                            input logic pb, input logic s1, input logic two, input logic s2);
    bit_out(1'b0);
    for (int i = 0; i < nbits; i++) bit_out(d[i]);
    if (pen) bit_out(pb);
    bit_out(s1);
    if (two) bit_out(s2);
    rx = 1'b1;
    repeat (16) @(posedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !empty) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (n >= 3000) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d entries still expected, empty=%b", name, exp_q.size(), empty);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_empty",   32'(empty),   32'd1);
    check("reset_full",    32'(full),    32'd0);
    check("reset_level",   32'(level),   32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_rts_n",   32'(rts_n),   32'd1);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_rd_err",  32'(rd_err),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rts_n_after_reset", 32'(rts_n), 32'd0);

    // 8N1 0xA5
    exp_q.push_back({3'b000, 8'hA5});
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain("8n1");

    // 8E1 0xB6 (five ones): parity 1 is correct, parity 0 is an error
    cfg_parity_en = 1'b1;
    cfg_parity_even = 1'b1;
    exp_q.push_back({3'b000, 8'hB6});
    send_frame(8'hB6, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({3'b001, 8'hB6});
    send_frame(8'hB6, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain("8e1");

    // 7O2 0x65 (four ones, odd parity bit 1), second stop driven low
    cfg_data_bits = 2'd2;
    cfg_parity_even = 1'b0;
    cfg_stop_bits = 1'b1;
    exp_q.push_back({3'b010, 8'h65});
    send_frame(8'h65, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_drain("7o2");

    // 5N1 0x1F
    cfg_data_bits = 2'd0;
    cfg_parity_en = 1'b0;
    cfg_stop_bits = 1'b0;
    exp_q.push_back({3'b000, 8'h1F});
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain("5n1");

    // Back to 8N1: glitch of 1.5 ticks must not produce an entry
    cfg_data_bits = 2'd3;
    rx = 1'b0;
    repeat (6) @(posedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(posedge clk);
    #1;
    check("false_start_level", 32'(level), 32'd0);
    check("false_start_empty", 32'(empty), 32'd1);

    // Reset in the middle of the data bits discards the partial frame
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * BIT_CLKS) @(posedge clk);
    #1;
    check("mid_reset_level", 32'(level), 32'd0);
    check("mid_reset_empty", 32'(empty), 32'd1);
    exp_q.push_back({3'b000, 8'h3C});
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain("after_reset");

    // Fill the FIFO without reading: 17th frame is dropped
    pop_limit = pops_done;
    for (int k = 1; k <= 17; k++) begin
      if (k <= 16) exp_q.push_back({3'b000, 8'(k * 7)});
      send_frame(8'(k * 7), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      #1;
      if (k == 13) check("rts_n_level13", 32'(rts_n), 32'd0);
      if (k == 14) check("rts_n_level14", 32'(rts_n), 32'd1);
      if (k == 16) check("overrun_before_drop", 32'(overrun), 32'd0);
    end
    check("full_level",   32'(level),   32'd16);
    check("full_flag",    32'(full),    32'd1);
    check("full_overrun", 32'(overrun), 32'd1);
    check("full_rts_n",   32'(rts_n),   32'd1);
    pop_limit = pops_done + 3;
    repeat (20) @(posedge clk);
    #1;
    check("pop3_level", 32'(level), 32'd13);
    check("pop3_full",  32'(full),  32'd0);
    check("pop3_rts_n", 32'(rts_n), 32'd0);
    check("pop3_overrun_sticky", 32'(overrun), 32'd1);
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    #1;
    check("ovr_clr", 32'(overrun), 32'd0);
    pop_limit = 1000000;
    wait_drain("fifo_drain");

    // Line held low for 20 bit times: exactly one break entry
`ifdef UART_RX_BREAK_DET_EN
    exp_q.push_back({3'b110, 8'h00});
`else
    exp_q.push_back({3'b010, 8'h00});
`endif
    rx = 1'b0;
    repeat (20 * BIT_CLKS) @(posedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    exp_q.push_back({3'b000, 8'h5A});
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain("break");
    repeat (4 * BIT_CLKS) @(posedge clk);
    #1;
    check("final_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
